// File: rtl/soft_rst_requester.sv
// Soft-reset requester: merges edge-triggered requests into one HOLD_CYC pulse and waits for the 125 MHz domain to enter and then leave reset.
// Optional lock-loss monitor is built only when SOFT_RST_LOCK_MON_EN is defined.
module soft_rst_requester #(
    parameter int NUM_SRC      = 4,
    parameter int HOLD_CYC     = 64,
    parameter int TIMEOUT_CYC  = 200000,
    parameter int COOLDOWN_CYC = 2000
) (
    input  logic               clk_200m,
    input  logic               rst_200m,
    input  logic [NUM_SRC-1:0] req_in,
    input  logic               rst_125m_sync,
    input  logic               mmcm_locked,
    output logic               soft_rst_req,
    output logic               busy,
    output logic [NUM_SRC:0]   last_cause,
    output logic               timeout_flag,
    output logic [15:0]        req_count
);

    localparam int MAX_HT  = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_HT > COOLDOWN_CYC) ? MAX_HT : COOLDOWN_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST     = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_ACK, S_COOLDOWN} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [NUM_SRC:0]   pending, pending_nx, last_cause_nx, req_edge;
    logic [NUM_SRC-1:0] req_in_d1;
    logic               seen_hi, seen_hi_nx, timeout_nx;
    logic [15:0]        req_count_nx;
    logic               lock_fall, lock_ok;

`ifdef SOFT_RST_LOCK_MON_EN
    logic lock_meta, lock_sync, lock_d1;

    always_ff @(posedge clk_200m) begin
        if (rst_200m) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            lock_d1   <= 1'b0;
        end else begin
            lock_meta <= mmcm_locked;
            lock_sync <= lock_meta;
            lock_d1   <= lock_sync;
        end
    end

    assign lock_fall = lock_d1 & ~lock_sync;
    assign lock_ok   = lock_sync;
`else
    logic unused_mmcm_locked;
    assign unused_mmcm_locked = mmcm_locked;
    assign lock_fall          = 1'b0;
    assign lock_ok            = 1'b1;
`endif

    assign req_edge = {lock_fall, req_in & ~req_in_d1};

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt + 1'b1;
        pending_nx    = pending | req_edge;
        last_cause_nx = last_cause;
        seen_hi_nx    = seen_hi;
        timeout_nx    = timeout_flag;
        req_count_nx  = req_count;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (pending != '0 && lock_ok) begin
                    state_nx      = S_ASSERT;
                    last_cause_nx = pending;
                    pending_nx    = req_edge;
                end
            end
            S_ASSERT: begin
                if (cnt == HOLD_LAST) begin
                    state_nx   = S_WAIT_ACK;
                    cnt_nx     = '0;
                    seen_hi_nx = 1'b0;
                end
            end
            S_WAIT_ACK: begin
                if (rst_125m_sync) seen_hi_nx = 1'b1;
                // ack is checked first so it wins over a coincident timeout
                if (seen_hi && !rst_125m_sync) begin
                    state_nx = S_COOLDOWN;
                    cnt_nx   = '0;
                    if (req_count != 16'hFFFF) req_count_nx = req_count + 16'd1;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx   = S_COOLDOWN;
                    cnt_nx     = '0;
                    timeout_nx = 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (cnt == COOLDOWN_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // outputs decoded from next state and registered, so the reset line never glitches
    always_ff @(posedge clk_200m) begin
        if (rst_200m) begin
            state        <= S_IDLE;
            cnt          <= '0;
            pending      <= '0;
            req_in_d1    <= req_in;
            seen_hi      <= 1'b0;
            last_cause   <= '0;
            timeout_flag <= 1'b0;
            req_count    <= '0;
            soft_rst_req <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            pending      <= pending_nx;
            req_in_d1    <= req_in;
            seen_hi      <= seen_hi_nx;
            last_cause   <= last_cause_nx;
            timeout_flag <= timeout_nx;
            req_count    <= req_count_nx;
            soft_rst_req <= (state_nx == S_ASSERT);
            busy         <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_soft_rst_requester.sv
// Bench for soft_rst_requester: directed vector table, hand-written corner sequences,
// and random stimulus checked every cycle against a sequential reference model.
module tb_soft_rst_requester;

    localparam int NUM_SRC = 4;
    localparam int HOLD    = 32;
    localparam int TO      = 150;
    localparam int CD      = 40;
    localparam int LIM     = HOLD + TO + CD + 20;

    logic       clk_200m = 1'b0;
    logic       rst_200m = 1'b1;
    logic [3:0] req_in = '0;
    logic       rst_125m_sync = 1'b0;
    logic       mmcm_locked = 1'b1;
    logic       soft_rst_req, busy, timeout_flag;
    logic [4:0] last_cause;
    logic [15:0] req_count;

    soft_rst_requester #(
        .NUM_SRC(NUM_SRC), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TO), .COOLDOWN_CYC(CD)
    ) dut (
        .clk_200m(clk_200m), .rst_200m(rst_200m), .req_in(req_in),
        .rst_125m_sync(rst_125m_sync), .mmcm_locked(mmcm_locked),
        .soft_rst_req(soft_rst_req), .busy(busy), .last_cause(last_cause),
        .timeout_flag(timeout_flag), .req_count(req_count)
    );

    always #5 clk_200m = ~clk_200m;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 125 MHz domain stand-in: enters reset ack_dly cycles into the request,
    // leaves it ack_tail cycles after the request drops
    bit ack_en   = 1;
    int ack_dly  = 5;
    int ack_tail = 3;
    int since    = 0;
    int tail     = 0;
    always @(negedge clk_200m) begin
        if (!ack_en) begin
            rst_125m_sync = 1'b0;
            since = 0;
        end else if (soft_rst_req === 1'b1) begin
            since++;
            if (since >= ack_dly) begin
                rst_125m_sync = 1'b1;
                tail = ack_tail;
            end
        end else begin
            since = 0;
            if (rst_125m_sync) begin
                if (tail == 0) rst_125m_sync = 1'b0;
                else tail--;
            end
        end
    end

    // reference model: one reset episode per loop pass, written as a program
    logic [4:0]  m_pend = '0, m_pend_pre = '0, m_e = '0;
    logic [3:0]  m_prev = '0;
    bit          m_abort, m_lock_pre, m_ack, m_seen;
    int          m_wait;
    logic        exp_req = 0, exp_busy = 0, exp_tflag = 0;
    logic [4:0]  exp_cause = '0;
    logic [15:0] exp_count = '0;
`ifdef SOFT_RST_LOCK_MON_EN
    logic m_lmeta = 0, m_lsync = 0, m_ld1 = 0;
`endif

    task automatic m_tick();
        logic fall;
        @(posedge clk_200m);
        if (rst_200m) begin
            m_abort = 1;
            exp_req = 0; exp_busy = 0; exp_tflag = 0; exp_cause = '0; exp_count = '0;
            m_pend = '0; m_pend_pre = '0; m_e = '0; m_prev = req_in; m_lock_pre = 0;
`ifdef SOFT_RST_LOCK_MON_EN
            m_lmeta = 0; m_lsync = 0; m_ld1 = 0;
`endif
        end else begin
`ifdef SOFT_RST_LOCK_MON_EN
            fall = m_ld1 & ~m_lsync;
            m_lock_pre = m_lsync;
            m_ld1 = m_lsync; m_lsync = m_lmeta; m_lmeta = mmcm_locked;
`else
            fall = 1'b0;
            m_lock_pre = 1;
`endif
            m_ack = rst_125m_sync;
            m_pend_pre = m_pend;
            m_e = {fall, req_in & ~m_prev};
            m_prev = req_in;
            m_pend = m_pend | m_e;
        end
    endtask

    initial begin : ref_model
        forever begin
            do begin
                m_abort = 0;
                m_tick();
            end while (m_pend_pre == '0 || !m_lock_pre);
            exp_cause = m_pend_pre;
            m_pend = m_e;
            exp_req = 1; exp_busy = 1;
            for (int i = 0; i < HOLD; i++) begin
                m_tick();
                if (m_abort) break;
            end
            if (m_abort) continue;
            exp_req = 0;
            m_seen = 0; m_wait = 0;
            forever begin
                m_tick();
                if (m_abort) break;
                if (m_seen && !m_ack) begin
                    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
                    break;
                end
                if (m_wait == TO - 1) begin
                    exp_tflag = 1;
                    break;
                end
                if (m_ack) m_seen = 1;
                m_wait++;
            end
            if (m_abort) continue;
            for (int i = 0; i < CD; i++) begin
                m_tick();
                if (m_abort) break;
            end
            if (m_abort) continue;
            exp_busy = 0;
        end
    end

    always @(posedge clk_200m) begin
        #2;
        if (chk_en)
            check("lockstep", {8'h0, soft_rst_req, busy, timeout_flag, last_cause, req_count},
                  {8'h0, exp_req, exp_busy, exp_tflag, exp_cause, exp_count});
    end

    task automatic pulse(input logic [3:0] m);
        @(negedge clk_200m); req_in = m;
        @(negedge clk_200m); req_in = '0;
    endtask

    task automatic wait_busy_low();
        int n = 0;
        while (busy !== 1'b0 && n < LIM) begin
            @(posedge clk_200m); #1; n++;
        end
    endtask

    task automatic wait_idle(input string name);
        wait_busy_low();
        check({name, "_idle"}, busy, 0);
    endtask

    typedef struct {
        logic [3:0]  mask;
        bit          ack;
        int          dly;
        int          tl;
        logic [4:0]  cause;
        logic [15:0] count;
        bit          tflag;
    } vec_t;
    vec_t vecs[6];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        vecs[0] = '{4'b0001, 1, 3,        2, 5'b00001, 16'd2, 0};
        vecs[1] = '{4'b1010, 1, 6,        4, 5'b01010, 16'd3, 0};
        vecs[2] = '{4'b0100, 1, HOLD - 1, 1, 5'b00100, 16'd4, 0};
        vecs[3] = '{4'b1111, 1, 1,        6, 5'b01111, 16'd5, 0};
        vecs[4] = '{4'b1000, 0, 3,        2, 5'b01000, 16'd5, 1};
        vecs[5] = '{4'b0010, 1, 10,       3, 5'b00010, 16'd6, 1};

        repeat (3) @(negedge clk_200m);
        chk_en = 1;
        check("rst_soft_req", soft_rst_req, 0);
        check("rst_busy", busy, 0);
        check("rst_cause", last_cause, 0);
        check("rst_tflag", timeout_flag, 0);
        check("rst_count", req_count, 0);
        rst_200m = 0;

        // T1: exact pulse position and width
        @(negedge clk_200m); req_in = 4'b0001;
        @(posedge clk_200m); #1;
        check("t1_not_early", soft_rst_req, 0);
        @(posedge clk_200m); #1;
        check("t1_rise", soft_rst_req, 1);
        n = 1;
        while (soft_rst_req === 1'b1 && n < HOLD + 10) begin
            @(posedge clk_200m); #1;
            if (soft_rst_req === 1'b1) n++;
        end
        check("t1_width", n, HOLD);
        req_in = '0;
        wait_idle("t1");
        check("t1_cause", last_cause, 5'b00001);
        check("t1_count", req_count, 1);

        for (int i = 0; i < 6; i++) begin
            ack_en = vecs[i].ack; ack_dly = vecs[i].dly; ack_tail = vecs[i].tl;
            pulse(vecs[i].mask);
            @(posedge clk_200m); #1;
            check("vec_start", busy, 1);
            wait_idle("vec");
            check("vec_cause", last_cause, vecs[i].cause);
            check("vec_count", req_count, vecs[i].count);
            check("vec_tflag", timeout_flag, vecs[i].tflag);
        end
        ack_dly = 5; ack_tail = 3;

        // T3: request during cooldown restarts right after idle
        pulse(4'b0001);
        repeat (HOLD + 16) @(posedge clk_200m);
        pulse(4'b0100);
        wait_busy_low();
        check("t3_gap", busy, 0);
        check("t3_first_cause", last_cause, 5'b00001);
        check("t3_first_count", req_count, 7);
        @(posedge clk_200m); #1;
        check("t3_restart", soft_rst_req, 1);
        wait_idle("t3");
        check("t3_cause", last_cause, 5'b00100);
        check("t3_count", req_count, 8);

        // coalescing: requests in ASSERT and COOLDOWN give one more reset
        pulse(4'b0001);
        repeat (3) @(posedge clk_200m);
        pulse(4'b0010);
        repeat (HOLD + 16) @(posedge clk_200m);
        pulse(4'b1000);
        wait_busy_low();
        check("co_first_count", req_count, 9);
        @(posedge clk_200m); #1;
        wait_idle("co");
        check("co_cause", last_cause, 5'b01010);
        check("co_count", req_count, 10);
        repeat (30) @(posedge clk_200m); #1;
        check("co_single", busy, 0);

        // T5: reset mid-pulse
        pulse(4'b1000);
        @(posedge clk_200m); #1;
        check("t5_assert", soft_rst_req, 1);
        repeat (19) @(posedge clk_200m);
        @(negedge clk_200m); rst_200m = 1;
        @(posedge clk_200m); #1;
        check("t5_soft_req", soft_rst_req, 0);
        check("t5_busy", busy, 0);
        check("t5_tflag", timeout_flag, 0);
        check("t5_count", req_count, 0);
        @(negedge clk_200m); rst_200m = 0;
        pulse(4'b0100);
        @(posedge clk_200m); #1;
        check("t5_again", busy, 1);
        wait_idle("t5");
        check("t5_cause", last_cause, 5'b00100);
        check("t5_count2", req_count, 1);

`ifdef SOFT_RST_LOCK_MON_EN
        // T6: lock loss holds off until relock, then resets with the lock cause
        @(negedge clk_200m); mmcm_locked = 0;
        repeat (100) @(posedge clk_200m); #1;
        check("t6_hold", busy, 0);
        @(negedge clk_200m); mmcm_locked = 1;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(posedge clk_200m); #1; n++;
        end
        check("t6_start", busy, 1);
        wait_idle("t6");
        check("t6_cause", last_cause, 5'b10000);
`endif

        // random traffic, acks and resets against the model
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk_200m);
            if ($urandom_range(0, 9) == 0) req_in = 4'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                ack_en   = ~ack_en;
                ack_dly  = $urandom_range(1, HOLD - 1);
                ack_tail = $urandom_range(1, 6);
            end
            rst_200m = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk_200m);
        rst_200m = 0; req_in = '0; ack_en = 1;
        repeat (600) @(posedge clk_200m); #1;
        check("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
